// File: rtl/fir_stream_core_if.sv
// Valid/ready sample stream between the streamer and the FIR datapath.
// The master drives data and valid. The slave drives ready.
interface fir_stream_core_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] dat;
  logic                  vld;
  logic                  rdy;

  modport master (output dat, output vld, input rdy);
  modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/fir_stream_core.sv
// Streaming N-tap FIR: one saturated, shifted output per accepted input. Output is registered 1 cycle after accept.
// Backpressure: input ready drops when the output slot is full and not draining, or when the job has taken len samples.
module fir_stream_core #(
  parameter int DATA_WIDTH = 32,
  parameter int COEF_WIDTH = 16,
  parameter int N_TAPS     = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic [5:0]                   shift_i,
  input  logic [N_TAPS*COEF_WIDTH-1:0] coef_i,
  fir_stream_core_if.slave             a,
  fir_stream_core_if.master            b,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [LEN_WIDTH-1:0]         cnt_o
);

  localparam int GUARD  = $clog2(N_TAPS);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = PROD_W + GUARD;
  localparam int HI_W   = ACC_W - DATA_WIDTH + 1;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                       r_state;
  logic signed [COEF_WIDTH-1:0] r_coef [N_TAPS];
  // Only the N_TAPS-1 past samples are stored; tap 0 is the sample being accepted.
  logic signed [DATA_WIDTH-1:0] r_x [N_TAPS-1];
  logic [LEN_WIDTH-1:0]         r_len;
  logic [LEN_WIDTH-1:0]         r_in_cnt;
  logic [LEN_WIDTH-1:0]         r_out_cnt;
  logic [5:0]                   r_shift;
  logic [DATA_WIDTH-1:0]        r_b_dat;
  logic                         r_b_vld;
  logic                         r_busy;
  logic                         r_done;

  logic signed [DATA_WIDTH-1:0] w_xn   [N_TAPS];
  logic signed [PROD_W-1:0]     w_prod [N_TAPS];
  logic signed [ACC_W-1:0]      w_sum;
  logic signed [ACC_W-1:0]      w_shr;
  logic [HI_W-1:0]              w_hi;
  logic                         w_fits;
  logic [DATA_WIDTH-1:0]        w_sat;
  logic                         w_a_rdy;
  logic                         w_accept;
  logic                         w_b_hs;
  logic                         w_last_out;

  always_comb begin
    w_xn[0] = signed'(a.dat);
    for (int k = 1; k < N_TAPS; k++) begin
      w_xn[k] = r_x[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < N_TAPS; k++) begin
      w_prod[k] = PROD_W'(r_coef[k]) * PROD_W'(w_xn[k]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      w_sum = w_sum + ACC_W'(w_prod[k]);
    end
  end

  // The result fits when every bit above the output sign bit equals that sign bit.
  assign w_shr  = w_sum >>> r_shift;
  assign w_hi   = w_shr[ACC_W-1:DATA_WIDTH-1];
  assign w_fits = (&w_hi) | ~(|w_hi);
  assign w_sat  = w_fits ? w_shr[DATA_WIDTH-1:0] : (w_shr[ACC_W-1] ? SAT_MIN : SAT_MAX);

  assign w_a_rdy    = (r_state == S_RUN) && (r_in_cnt < r_len) && (!r_b_vld || b.rdy);
  assign w_accept   = a.vld && w_a_rdy;
  assign w_b_hs     = r_b_vld && b.rdy;
  assign w_last_out = w_b_hs && ((r_out_cnt + LEN_WIDTH'(1)) == r_len);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_shift   <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_b_dat   <= '0;
      r_b_vld   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        r_coef[k] <= '0;
      end
      for (int k = 0; k < N_TAPS-1; k++) begin
        r_x[k] <= '0;
      end
    end else if (clear_i) begin
      r_state   <= S_IDLE;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_b_dat   <= '0;
      r_b_vld   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int k = 0; k < N_TAPS-1; k++) begin
        r_x[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_len     <= len_i;
            r_shift   <= shift_i;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            for (int k = 0; k < N_TAPS; k++) begin
              r_coef[k] <= coef_i[k*COEF_WIDTH +: COEF_WIDTH];
            end
            for (int k = 0; k < N_TAPS-1; k++) begin
              r_x[k] <= '0;
            end
            if (len_i != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Accept and drain may coincide: the output slot is refilled on the same edge.
          if (w_accept) begin
            for (int k = 0; k < N_TAPS-1; k++) begin
              r_x[k] <= w_xn[k];
            end
            r_in_cnt <= r_in_cnt + LEN_WIDTH'(1);
            r_b_dat  <= w_sat;
            r_b_vld  <= 1'b1;
          end else if (w_b_hs) begin
            r_b_vld <= 1'b0;
          end
          if (w_b_hs) begin
            r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
          end
          if (w_last_out) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign a.rdy  = w_a_rdy;
  assign b.dat  = r_b_dat;
  assign b.vld  = r_b_vld;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign cnt_o  = r_out_cnt;

endmodule
